// File: rtl/umem_pkg.sv
// Shared types and address-decode helpers for the line-wide memory responder.
package umem_pkg;

    localparam int LINE_BYTES  = 64;
    localparam int OFFSET_BITS = 6;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        ACK,
        RELEASE
    } resp_state_e;

    function automatic logic [63:0] line_of(input logic [63:0] addr);
        return addr >> OFFSET_BITS;
    endfunction

    // Banks are line-interleaved, so the bank is the low bits of the line index.
    function automatic logic [63:0] bank_of(input logic [63:0] line, input int bank_bits);
        return line & ((64'd1 << bank_bits) - 64'd1);
    endfunction

    function automatic logic [63:0] row_of(input logic [63:0] line, input int bank_bits,
                                           input int row_bits);
        return line >> (bank_bits + row_bits);
    endfunction

endpackage

// File: rtl/umem_bank_row_table.sv
// Per-bank open-row registers; lookup reports a hit on the presented bank/row,
// open records that row as the one now open in the bank. Reset closes every row.
import umem_pkg::*;

module umem_bank_row_table #(
    parameter int NUM_BANKS = 16,
    parameter int BANK_W    = 4,
    parameter int ROW_W     = 19
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BANK_W-1:0] bank,
    input  logic [ROW_W-1:0]  row,
    input  logic              open,
    output logic              hit
);

    logic [ROW_W-1:0]     row_q [NUM_BANKS];
    logic [NUM_BANKS-1:0] vld_q;

    assign hit = vld_q[bank] && (row_q[bank] == row);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < NUM_BANKS; i++) begin
                row_q[i] <= '0;
            end
        end else if (open) begin
            vld_q[bank] <= 1'b1;
            row_q[bank] <= row;
        end
    end

endmodule

// File: rtl/line_memory_responder.sv
// Line-wide memory responder: one request at a time, ack after a row-hit or
// row-miss latency, with sticky out-of-range flag and hit/miss statistics.
import umem_pkg::*;

module line_memory_responder #(
    parameter int ADDR_WIDTH  = 32,
    parameter int LINE_WIDTH  = 512,
    parameter int DEPTH_LINES = 1024,
    parameter int NUM_BANKS   = 16,
    parameter int ROW_LINES   = 8,
    parameter int T_HIT       = 2,
    parameter int T_MISS      = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [LINE_WIDTH-1:0] mem_wdata,
    output logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_req,
    input  logic                  mem_we,
    output logic                  mem_ack,
    output logic                  range_err,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
);

    localparam int BANK_BITS = $clog2(NUM_BANKS);
    localparam int BANK_W    = (BANK_BITS > 0) ? BANK_BITS : 1;
    localparam int ROW_BITS  = $clog2(ROW_LINES);
    localparam int IDX_W     = $clog2(DEPTH_LINES);
    localparam int ROW_RAW   = ADDR_WIDTH - OFFSET_BITS - BANK_BITS - ROW_BITS;
    localparam int ROW_W     = (ROW_RAW > 0) ? ROW_RAW : 1;
    localparam int CNT_W     = $clog2(T_MISS) + 1;

    localparam logic [CNT_W-1:0] LOAD_HIT  = CNT_W'(T_HIT - 1);
    localparam logic [CNT_W-1:0] LOAD_MISS = CNT_W'(T_MISS - 1);

    resp_state_e           state_q, next_state;
    logic [CNT_W-1:0]      cnt_q;
    logic                  we_q;
    logic                  oor_q;
    logic [IDX_W-1:0]      idx_q;
    logic [LINE_WIDTH-1:0] wdata_q;
    logic [LINE_WIDTH-1:0] storage [DEPTH_LINES];

    logic [63:0]       req_line;
    logic [BANK_W-1:0] req_bank;
    logic [ROW_W-1:0]  req_row;
    logic [IDX_W-1:0]  req_idx;
    logic              req_oor;
    logic              row_hit;
    logic              accept;
    logic              do_access;

    assign req_line = line_of(64'(mem_addr));
    assign req_bank = BANK_W'(bank_of(req_line, BANK_BITS));
    assign req_row  = ROW_W'(row_of(req_line, BANK_BITS, ROW_BITS));
    assign req_idx  = IDX_W'(req_line);
    assign req_oor  = (req_line >= 64'(DEPTH_LINES));

    umem_bank_row_table #(
        .NUM_BANKS (NUM_BANKS),
        .BANK_W    (BANK_W),
        .ROW_W     (ROW_W)
    ) u_row_table (
        .clk   (clk),
        .rst_n (rst_n),
        .bank  (req_bank),
        .row   (req_row),
        .open  (accept),
        .hit   (row_hit)
    );

    always_comb begin
        next_state = state_q;
        accept     = 1'b0;
        do_access  = 1'b0;
        mem_ack    = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_req) begin
                    accept     = 1'b1;
                    next_state = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    do_access  = 1'b1;
                    next_state = ACK;
                end
            end
            ACK: begin
                mem_ack    = 1'b1;
                next_state = RELEASE;
            end
            RELEASE: begin
                // A request still held from the last transfer must drop first.
                if (!mem_req) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            oor_q      <= 1'b0;
            idx_q      <= '0;
            mem_rdata  <= '0;
            range_err  <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            state_q <= next_state;
            if (accept) begin
                we_q  <= mem_we;
                oor_q <= req_oor;
                idx_q <= req_idx;
                if (row_hit) begin
                    cnt_q     <= LOAD_HIT;
                    hit_count <= hit_count + 32'd1;
                end else begin
                    cnt_q      <= LOAD_MISS;
                    miss_count <= miss_count + 32'd1;
                end
                if (req_oor) begin
                    range_err <= 1'b1;
                end
            end
            if (state_q == ACCESS && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (do_access && !we_q) begin
                mem_rdata <= oor_q ? '0 : storage[idx_q];
            end
        end
    end

    // Data path carries no reset; a write only lands on the ACCESS->ACK edge.
    always_ff @(posedge clk) begin
        if (accept) begin
            wdata_q <= mem_wdata;
        end
        if (do_access && we_q && !oor_q) begin
            storage[idx_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_line_memory_responder.sv
// Directed bench for line_memory_responder: latency, row state, counters,
// out-of-range handling, request holding and mid-operation reset.
module tb_line_memory_responder;

    logic         clk;
    logic         rst_n;
    logic [31:0]  mem_addr;
    logic [511:0] mem_wdata;
    logic [511:0] mem_rdata;
    logic         mem_req;
    logic         mem_we;
    logic         mem_ack;
    logic         range_err;
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;

    int checks = 0;
    int errors = 0;
    logic [511:0] rd;
    logic [511:0] pat_a5;
    logic [511:0] pat_5a;
    logic [511:0] pat_ff;
    logic [511:0] pat_33;

    line_memory_responder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_ack    (mem_ack),
        .range_err  (range_err),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Issue one request from IDLE; check latency, single-cycle ack, and that a
    // request held for `hold` extra cycles is neither re-accepted nor counted.
    task automatic do_req(input string tag, input logic [31:0] addr, input logic we,
                          input logic [511:0] wd, input int exp_lat, input int hold);
        int lat;
        logic [31:0] hc;
        logic [31:0] mc;
        mem_addr  = addr;
        mem_we    = we;
        mem_wdata = wd;
        mem_req   = 1'b1;
        @(posedge clk);
        #1;
        mem_addr  = 32'hFFFF_FFC0;
        mem_we    = ~we;
        mem_wdata = '1;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (mem_ack) begin
                lat = i;
                break;
            end
        end
        chk({tag, "_lat"}, lat, exp_lat);
        rd = mem_rdata;
        hc = hit_count;
        mc = miss_count;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({tag, "_hold_ack"}, mem_ack, 1'b0);
        end
        if (hold > 0) begin
            chk({tag, "_hold_cnt"}, {hit_count, miss_count}, {hc, mc});
        end
        mem_req = 1'b0;
        if (hold == 0) begin
            @(posedge clk);
            #1;
            chk({tag, "_ack_pulse"}, mem_ack, 1'b0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        pat_a5 = {64{8'hA5}};
        pat_5a = {64{8'h5A}};
        pat_ff = {64{8'hFF}};
        pat_33 = {64{8'h33}};

        // Reset state
        do_reset();
        chk("rst_ack", mem_ack, 1'b0);
        chk("rst_rdata", mem_rdata, 512'd0);
        chk("rst_range_err", range_err, 1'b0);
        chk("rst_hits", hit_count, 32'd0);
        chk("rst_misses", miss_count, 32'd0);

        // Closed row after reset -> miss latency
        do_req("rd0", 32'h0, 1'b0, '0, 6, 0);
        chk("rd0_miss", miss_count, 32'd1);
        chk("rd0_hit", hit_count, 32'd0);

        // Write bank 1 (miss), read back (hit)
        do_req("wr40", 32'h40, 1'b1, pat_a5, 6, 0);
        do_req("rd40", 32'h40, 1'b0, '0, 2, 0);
        chk("rd40_data", rd, pat_a5);
        chk("rd40_data_stable", mem_rdata, pat_a5);
        chk("rd40_hits", hit_count, 32'd1);
        chk("rd40_misses", miss_count, 32'd2);

        // Same bank, alternating rows -> every access misses
        do_reset();
        do_req("rowA", 32'h0, 1'b0, '0, 6, 0);
        do_req("rowB", 32'h2000, 1'b0, '0, 6, 0);
        do_req("rowA2", 32'h0, 1'b0, '0, 6, 0);
        chk("row_misses", miss_count, 32'd3);
        chk("row_hits", hit_count, 32'd0);

        // Request held after ack, then a fresh request right after IDLE
        do_req("hold", 32'h40, 1'b0, '0, 6, 3);
        chk("hold_misses", miss_count, 32'd4);
        do_req("reacc", 32'h40, 1'b0, '0, 2, 0);
        chk("reacc_hits", hit_count, 32'd1);

        // Out-of-range line 1024 aliases bank 0 row 8
        do_req("wr0", 32'h0, 1'b1, pat_5a, 2, 0);
        do_req("rd_oor", 32'h0001_0000, 1'b0, '0, 6, 0);
        chk("oor_rdata", rd, 512'd0);
        chk("oor_range_err", range_err, 1'b1);
        do_req("wr_oor", 32'h0001_0000, 1'b1, pat_ff, 2, 0);
        do_req("rd0_after_oor", 32'h0, 1'b0, '0, 6, 0);
        chk("line0_intact", rd, pat_5a);
        chk("oor_sticky", range_err, 1'b1);
        chk("oor_hits", hit_count, 32'd3);
        chk("oor_misses", miss_count, 32'd6);

        // Reset while a write sits in ACCESS: no ack, write lost
        mem_addr  = 32'h0;
        mem_we    = 1'b1;
        mem_wdata = pat_33;
        mem_req   = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_ack", mem_ack, 1'b0);
        chk("midrst_counts", {hit_count, miss_count}, 64'd0);
        chk("midrst_range_err", range_err, 1'b0);
        chk("midrst_rdata", mem_rdata, 512'd0);
        mem_req = 1'b0;
        mem_we  = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            chk("midrst_no_ack", mem_ack, 1'b0);
        end
        do_req("rd_after_rst", 32'h0, 1'b0, '0, 6, 0);
        chk("write_lost", rd, pat_5a);
        chk("after_rst_misses", miss_count, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
